// File: rtl/clkmon_burst_if.sv
// Control/status and pad-handshake signals of the clock-monitor burst sequencer.
interface clkmon_burst_if #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
);
  logic [DIV_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_count;
  logic             start;
  logic             stop;
  logic             pad_gnt;
  logic             pad_req;
  logic             mon_out;
  logic             mon_oeb;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output cfg_div, cfg_count, start, stop, pad_gnt,
    input  pad_req, mon_out, mon_oeb, busy, done, err, pulse_cnt
  );

  modport slave (
    input  cfg_div, cfg_count, start, stop, pad_gnt,
    output pad_req, mon_out, mon_oeb, busy, done, err, pulse_cnt
  );
endinterface

// File: rtl/clkmon_burst_ctrl.sv
// Clock-monitor pad sequencer: request pad, emit a bounded divided-clock burst,
// then tristate and release. done/err are registered one-cycle pulses.
module clkmon_burst_ctrl #(
  parameter int DIV_W       = 8,
  parameter int CNT_W       = 8,
  parameter int GNT_TIMEOUT = 16
) (
  input logic           clock,
  input logic           resetb,
  clkmon_burst_if.slave bus
);
  localparam int TMO_W = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(GNT_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RUN, REL} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_cnt;
  logic [CNT_W-1:0] count_q, pulse_q;
  logic [TMO_W-1:0] tmo_q;
  logic             mon_q, stop_pend, done_q, err_q;
  logic             done_d, err_d;
  logic             terminal, burst_end;

  assign terminal  = (div_cnt == div_q);
  assign burst_end = (count_q != '0) && (pulse_q == count_q);

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = REQ;
      REQ: begin
        // Stop wins over a same-cycle grant so the pad is never driven.
        if (bus.stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (bus.pad_gnt) begin
          state_d = RUN;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      RUN: begin
        if (!bus.pad_gnt) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (!mon_q && bus.stop) begin
          state_d = REL;
        end else if (mon_q && terminal && (bus.stop || stop_pend || burst_end)) begin
          state_d = REL;
        end
      end
      REL: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.pad_req = (state_q != IDLE);
    bus.busy    = (state_q != IDLE);
    bus.mon_oeb = (state_q != RUN);
  end

  assign bus.mon_out   = mon_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.pulse_cnt = pulse_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      div_q     <= '0;
      count_q   <= '0;
      div_cnt   <= '0;
      pulse_q   <= '0;
      tmo_q     <= '0;
      mon_q     <= 1'b0;
      stop_pend <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      case (state_q)
        IDLE: if (bus.start) begin
          div_q     <= bus.cfg_div;
          count_q   <= bus.cfg_count;
          pulse_q   <= '0;
          tmo_q     <= '0;
          stop_pend <= 1'b0;
        end
        REQ: begin
          tmo_q   <= tmo_q + TMO_W'(1);
          div_cnt <= '0;
          mon_q   <= 1'b0;
        end
        RUN: begin
          if (state_d == RUN) begin
            if (terminal) begin
              div_cnt <= '0;
              mon_q   <= ~mon_q;
              if (!mon_q) pulse_q <= pulse_q + CNT_W'(1);
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
            // A stop seen mid-high-phase must survive until the falling toggle.
            if (bus.stop && mon_q) stop_pend <= 1'b1;
          end else begin
            mon_q <= 1'b0;
          end
        end
        default: mon_q <= 1'b0;
      endcase
    end
  end
endmodule

// File: doc/clkmon_burst_ctrl.md
# clkmon_burst_ctrl

Sequencer for the housekeeping clock-monitor pad output. On command it requests ownership of a GPIO pad from the pad-configuration logic and waits for the grant. It then drives a divided core-clock waveform on the pad for a programmed number of pulses, or continuously until stopped, and finally tristates and releases the pad. Sits between the system-control registers and the GPIO pad mux, and replaces free-running clock-monitor enables with bounded, countable bursts.

## Interface
- DIV_W, 8, divider field width
- CNT_W, 8, pulse-count field width
- GNT_TIMEOUT, 16, cycles to wait in REQ for pad_gnt before aborting (≥1)

- clock  in  1  core clock; all logic on rising edge
- resetb  in  1  asynchronous active-low reset
- cfg_div  in  DIV_W  half-period minus one, in clock cycles; latched at start
- cfg_count  in  CNT_W  rising edges to emit; 0 = continuous; latched at start
- start  in  1  single-cycle launch request
- stop  in  1  level or pulse; graceful termination request
- pad_gnt  in  1  pad ownership grant from pad-config logic
- pad_req  out  1  pad ownership request
- mon_out  out  1  monitor waveform to pad
- mon_oeb  out  1  pad output enable, active low
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse on normal completion or stop
- err  out  1  one-cycle pulse on grant timeout or grant loss
- pulse_cnt  out  CNT_W  rising edges emitted in current/last burst

## Operation
- Reset values: pad_req=0, mon_out=0, mon_oeb=1, busy=0, done=0, err=0, pulse_cnt=0, state=IDLE. Reset asserted mid-operation forces these values immediately; no release handshake.
- IDLE: start → latch cfg_div/cfg_count, clear pulse_cnt, go to REQ. stop ignored. start and stop in the same IDLE cycle: start taken, stop ignored.
- REQ: pad_req=1, mon_oeb=1.
  - pad_gnt=1 → RUN, clearing the divider counter.
  - stop → IDLE with done pulse; err stays 0.
  - GNT_TIMEOUT cycles in REQ without grant → IDLE with err pulse.
- RUN: pad_req=1, mon_oeb=0.
  - Divider counts 0..div_q; at terminal value mon_out toggles and the counter reloads 0.
  - Each 0→1 toggle increments pulse_cnt; wraps modulo 2^CNT_W in continuous mode.
  - count_q≠0: after the falling toggle that follows the count_q-th rising edge → RELEASE.
  - stop with mon_out=0 → RELEASE next edge. Stop with mon_out=1 → finish the high phase; the falling toggle → RELEASE. No new rising edge after stop is sampled.
  - pad_gnt=0 → IDLE immediately (mon_oeb=1, mon_out=0, pad_req=0) with err pulse.
- RELEASE (one cycle): mon_oeb=1, mon_out=0, pad_req=1. Then IDLE with done pulse and pad_req=0.
- start while busy ignored. cfg_* changes after start ignored. pulse_cnt holds after done/err until the next start.
- cfg_div=0: mon_out toggles every cycle (period 2).

## Timing
- start sampled at edge 0 → pad_req=1, busy=1 after edge 0.
- pad_gnt sampled high at edge k → mon_oeb=0 after edge k. First rising toggle after edge k+D+1 (D=div_q).
- Waveform period 2(D+1); high and low phases each D+1 cycles.
- Burst of N: RUN lasts 2N(D+1) cycles. The RELEASE cycle follows. done is high, and pad_req low, in the cycle after RELEASE.
- Grant timeout: with no grant, err is high in cycle GNT_TIMEOUT+1 after start; pad_req falls in the same cycle.
- done and err never assert together; each is exactly one cycle.

## Test plan
- cfg_div=0, cfg_count=3, pad_gnt tied 1, start → 3 mon_out pulses of period 2. mon_oeb low for exactly 6 cycles, one done pulse, pulse_cnt=3, err=0.
- cfg_div=4, cfg_count=11 → 11 rising edges, each high 5 / low 5 cycles. pulse_cnt=11. Bench edge counter equals 11.
- pad_gnt held 0, start → pad_req high for 16 cycles, then err pulse. mon_oeb stays 1 throughout, busy=0 afterwards.
- cfg_count=0, cfg_div=2, stop asserted mid high phase → high phase completes at 3 cycles, no further rising edge, RELEASE, done.
- pad_gnt dropped after 5 rising edges → mon_oeb=1 and mon_out=0 next cycle, err pulse, pulse_cnt=5. Second start during that run was ignored.
- resetb asserted mid-RUN → all outputs at reset values asynchronously. After release, a start runs a normal burst.
